rxuart_param: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver in the serial section. It runs entirely on the system clock using a clock-enable oversampling tick; there is no derived clock. It supports configurable data width, parity and stop bits, and filters noise with a 3-sample majority vote. It reports parity, framing and break conditions alongside each received word, and feeds the UART RX FIFO/bus bridge through a one-cycle write strobe.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/rxuart_param.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and baud-divider sizing.
// Used by the parametrised receiver and the planned parametrised transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRKWAIT
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_divisor(input int clock_rate, input int baud_rate, input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

    // A counter that reaches DIVISOR-1 needs $clog2(DIVISOR) bits; never less than one.
    function automatic int divisor_width(input int divisor);
        return (divisor < 2) ? 1 : $clog2(divisor);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running clock-enable divider: one-cycle o_tick every DIVISOR clocks,
// with a synchronous clear used to phase-align to a start edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIVISOR = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = divisor_width(DIVISOR);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // A clear wins over a pending tick so the new bit period starts cleanly.
    assign o_tick = (cnt_reg == CNT_LAST) && !i_clear;

endmodule

// File: rtl/rxuart_param.sv
// Parametrised UART receiver: oversampled 3-sample majority vote, optional parity,
// 1 or 2 stop bits, per-frame parity/framing/break flags and a one-cycle write strobe.
module rxuart_param
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_uart_rx,
    output logic                 o_wr,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break
);

    localparam int DIVISOR = calc_divisor(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;
    localparam int TCW     = $clog2(OVERSAMPLE);

    localparam logic [TCW-1:0] T_LAST   = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] T_S0     = TCW'(M - 1);
    localparam logic [TCW-1:0] T_S1     = TCW'(M);
    localparam logic [TCW-1:0] T_DECIDE = TCW'(M + 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("rxuart_param: DATA_BITS must be in 5..9");
        end
        if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_oversample
            $error("rxuart_param: OVERSAMPLE must be even and at least 8");
        end
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("rxuart_param: CLOCK_RATE/(BAUD_RATE*OVERSAMPLE) must be at least 2");
        end
        if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
            $error("rxuart_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("rxuart_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // Input path
    logic [1:0] sync_reg;
    logic       last_reg;
    logic [1:0] valid_reg;
    logic       armed_reg;
    logic       rx_sync;
    logic       start_edge;

    assign rx_sync = sync_reg[1];

    // Start edges are only armed once the synchroniser holds a real idle-high line,
    // so a line that is already low when reset releases is not mistaken for a start.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_reg  <= 2'b11;
            last_reg  <= 1'b1;
            valid_reg <= 2'b00;
            armed_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], i_uart_rx};
            last_reg  <= sync_reg[1];
            valid_reg <= {valid_reg[0], 1'b1};
            if (valid_reg[1] && sync_reg[1]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign start_edge = armed_reg && last_reg && !rx_sync;

    // Oversampling tick
    uart_state_t state_reg;
    logic        tick;
    logic        baud_clear;

    assign baud_clear = (state_reg == ST_IDLE) && start_edge;

    uart_baud_tick #(
        .DIVISOR(DIVISOR)
    ) u_baud_tick (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clear(baud_clear),
        .o_tick (tick)
    );

    // Frame state
    logic [TCW-1:0]       tick_cnt_reg;
    logic [1:0]           samp_reg;
    logic [3:0]           bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 pbit_reg;
    logic                 stop_low_reg;
    logic                 stop_high_reg;

    logic                 wr_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 perr_reg;
    logic                 ferr_reg;
    logic                 brk_reg;

    logic maj;
    logic sample_pt;
    logic stop_low_next;
    logic stop_high_next;
    logic exp_pbit;
    logic perr_next;
    logic brk_next;

    // Third sample is the live synchronised line at tick M+1.
    assign maj            = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_sync) | (samp_reg[1] & rx_sync);
    assign sample_pt      = tick && (tick_cnt_reg == T_DECIDE);
    assign stop_low_next  = stop_low_reg | ~maj;
    assign stop_high_next = stop_high_reg | maj;
    assign exp_pbit       = (PARITY == PAR_ODD) ? ~(^shift_reg) : (^shift_reg);
    assign perr_next      = (PARITY != PAR_NONE) && (pbit_reg != exp_pbit);
    // A break keeps the line low through data, parity and every stop bit.
    assign brk_next       = (shift_reg == '0) && !pbit_reg && !stop_high_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= ST_IDLE;
            tick_cnt_reg  <= '0;
            samp_reg      <= 2'b00;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= '0;
            pbit_reg      <= 1'b0;
            stop_low_reg  <= 1'b0;
            stop_high_reg <= 1'b0;
            wr_reg        <= 1'b0;
            data_reg      <= '0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            brk_reg       <= 1'b0;
        end else begin
            wr_reg <= 1'b0;

            if (tick && state_reg != ST_IDLE) begin
                tick_cnt_reg <= (tick_cnt_reg == T_LAST) ? '0 : tick_cnt_reg + TCW'(1);
                if (tick_cnt_reg == T_S0) begin
                    samp_reg[0] <= rx_sync;
                end
                if (tick_cnt_reg == T_S1) begin
                    samp_reg[1] <= rx_sync;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_reg    <= ST_START;
                        tick_cnt_reg <= '0;
                    end
                end
                ST_START: begin
                    if (sample_pt) begin
                        if (maj) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg     <= ST_DATA;
                            bit_cnt_reg   <= 4'd0;
                            pbit_reg      <= 1'b0;
                            stop_low_reg  <= 1'b0;
                            stop_high_reg <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_pt) begin
                        shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_pt) begin
                        pbit_reg  <= maj;
                        state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample_pt) begin
                        if (bit_cnt_reg == STOP_LAST) begin
                            wr_reg        <= 1'b1;
                            data_reg      <= shift_reg;
                            perr_reg      <= perr_next;
                            ferr_reg      <= stop_low_next;
                            brk_reg       <= brk_next;
                            bit_cnt_reg   <= 4'd0;
                            stop_low_reg  <= 1'b0;
                            stop_high_reg <= 1'b0;
                            state_reg     <= brk_next ? ST_BRKWAIT : ST_IDLE;
                        end else begin
                            bit_cnt_reg   <= bit_cnt_reg + 4'd1;
                            stop_low_reg  <= stop_low_next;
                            stop_high_reg <= stop_high_next;
                        end
                    end
                end
                ST_BRKWAIT: begin
                    if (rx_sync) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wr         = wr_reg;
    assign o_data       = data_reg;
    assign o_parity_err = perr_reg;
    assign o_frame_err  = ferr_reg;
    assign o_break      = brk_reg;

endmodule
